// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester single-port memory arbiter (optional ARB_ROUND_ROBIN_EN)
module mem_arbiter (
    input  logic        clk,
    input  logic        rstb,
    input  logic [31:0] m0_addr,
    input  logic        m0_rd_req,
    input  logic        m0_wr_req,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_wr_data,
    output logic        m0_rd_ready,
    output logic        m0_wr_ready,
    output logic [31:0] m0_rd_data,
    input  logic [31:0] m1_addr,
    input  logic        m1_rd_req,
    input  logic        m1_wr_req,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_wr_data,
    output logic        m1_rd_ready,
    output logic        m1_wr_ready,
    output logic [31:0] m1_rd_data,
    output logic        mem_cs,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   r_owner;
    logic   r_is_wr;

    logic   w_m0_pend;
    logic   w_m1_pend;
    logic   w_any;
    logic   w_win;
    logic   w_win_wr;
    logic   w_issue;
    logic   w_unused;

    // byte-offset bits never reach the word-addressed memory
    assign w_unused = &{1'b0, m0_addr[1:0], m1_addr[1:0]};

    // pending requests and the access that would issue this cycle
    always_comb begin
        w_m0_pend = m0_rd_req | m0_wr_req;
        w_m1_pend = m1_rd_req | m1_wr_req;
        w_any     = w_m0_pend | w_m1_pend;
        w_issue   = rstb & (r_state == ST_IDLE) & w_any;
    end

`ifdef ARB_ROUND_ROBIN_EN
    logic r_rr_ptr;

    // pointer names the requester favoured on the next contention
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_rr_ptr <= 1'b0;
        end else if (w_issue) begin
            r_rr_ptr <= ~w_win;
        end
    end

    // winner: the sole requester, or the favoured one on contention
    always_comb begin
        w_win    = w_m0_pend ? (w_m1_pend & r_rr_ptr) : 1'b1;
        w_win_wr = w_win ? m1_wr_req : m0_wr_req;
    end
`else
    // winner: m0 always takes precedence
    always_comb begin
        w_win    = ~w_m0_pend;
        w_win_wr = w_win ? m1_wr_req : m0_wr_req;
    end
`endif

    // state register with latched owner and access type
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_is_wr <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_issue) begin
                r_owner <= w_win;
                r_is_wr <= w_win_wr;
            end
        end
    end

    // next state: an issue always takes exactly one response cycle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_any) w_next_state = ST_RESP;
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // outputs: memory strobe on issue, owner-only ready and data on response
    always_comb begin
        mem_cs      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = 30'd0;
        mem_be      = 4'h0;
        mem_wdata   = 32'd0;
        m0_rd_ready = 1'b0;
        m0_wr_ready = 1'b0;
        m0_rd_data  = 32'd0;
        m1_rd_ready = 1'b0;
        m1_wr_ready = 1'b0;
        m1_rd_data  = 32'd0;
        if (w_issue) begin
            mem_cs   = 1'b1;
            mem_we   = w_win_wr;
            mem_addr = w_win ? m1_addr[31:2] : m0_addr[31:2];
            if (w_win_wr) begin
                mem_be    = w_win ? m1_be : m0_be;
                mem_wdata = w_win ? m1_wr_data : m0_wr_data;
            end else begin
                mem_be    = 4'hF;
            end
        end else if (rstb && (r_state == ST_RESP)) begin
            if (r_owner) begin
                m1_rd_ready = ~r_is_wr;
                m1_wr_ready = r_is_wr;
                m1_rd_data  = mem_rdata;
            end else begin
                m0_rd_ready = ~r_is_wr;
                m0_wr_ready = r_is_wr;
                m0_rd_data  = mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rstb;
    logic [31:0] m0_addr, m1_addr, m0_wr_data, m1_wr_data, m0_rd_data, m1_rd_data;
    logic        m0_rd_req, m0_wr_req, m1_rd_req, m1_wr_req;
    logic [3:0]  m0_be, m1_be;
    logic        m0_rd_ready, m0_wr_ready, m1_rd_ready, m1_wr_ready;
    logic        mem_cs, mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    // requester agents: one held request per port
    logic        p_rd   [2];
    logic        p_wr   [2];
    logic [31:0] p_addr [2];
    logic [3:0]  p_be   [2];
    logic [31:0] p_data [2];

    assign m0_rd_req  = p_rd[0];
    assign m0_wr_req  = p_wr[0];
    assign m0_addr    = p_addr[0];
    assign m0_be      = p_be[0];
    assign m0_wr_data = p_data[0];
    assign m1_rd_req  = p_rd[1];
    assign m1_wr_req  = p_wr[1];
    assign m1_addr    = p_addr[1];
    assign m1_be      = p_be[1];
    assign m1_wr_data = p_data[1];

    mem_arbiter dut (
        .clk(clk), .rstb(rstb),
        .m0_addr(m0_addr), .m0_rd_req(m0_rd_req), .m0_wr_req(m0_wr_req), .m0_be(m0_be),
        .m0_wr_data(m0_wr_data), .m0_rd_ready(m0_rd_ready), .m0_wr_ready(m0_wr_ready),
        .m0_rd_data(m0_rd_data),
        .m1_addr(m1_addr), .m1_rd_req(m1_rd_req), .m1_wr_req(m1_wr_req), .m1_be(m1_be),
        .m1_wr_data(m1_wr_data), .m1_rd_ready(m1_rd_ready), .m1_wr_ready(m1_wr_ready),
        .m1_rd_data(m1_rd_data),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // memory device: 16 words, read data one cycle after the strobe
    logic [31:0] tb_mem [16];
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) tb_mem[mem_addr[3:0]][8*b +: 8] = mem_wdata[8*b +: 8];
            end else begin
                mem_rdata = tb_mem[mem_addr[3:0]];
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // reference model: transaction-level view of the arbiter
    logic [31:0] ref_mem [16];
    bit          e_resp, e_owner, e_wr, pref;
    logic [31:0] e_rdata;
    bit          seen_rd [2];
    bit          seen_wr [2];

    task automatic check_no_ready();
        check_eq("m0_rd_ready", m0_rd_ready, 0);
        check_eq("m0_wr_ready", m0_wr_ready, 0);
        check_eq("m1_rd_ready", m1_rd_ready, 0);
        check_eq("m1_wr_ready", m1_wr_ready, 0);
    endtask

    task automatic model_step();
        bit          pend0, pend1, win, wr;
        logic [31:0] a;
        pend0 = p_rd[0] | p_wr[0];
        pend1 = p_rd[1] | p_wr[1];
        seen_rd[0] = m0_rd_ready;
        seen_wr[0] = m0_wr_ready;
        seen_rd[1] = m1_rd_ready;
        seen_wr[1] = m1_wr_ready;
        if (e_resp) begin
            check_eq("resp_mem_cs", mem_cs, 0);
            check_eq("m0_rd_ready", m0_rd_ready, (e_owner == 0) && !e_wr);
            check_eq("m0_wr_ready", m0_wr_ready, (e_owner == 0) && e_wr);
            check_eq("m1_rd_ready", m1_rd_ready, (e_owner == 1) && !e_wr);
            check_eq("m1_wr_ready", m1_wr_ready, (e_owner == 1) && e_wr);
            if (e_owner == 0) begin
                check_eq("m1_rd_data_nonowner", m1_rd_data, 0);
                if (!e_wr) check_eq("m0_rd_data", m0_rd_data, e_rdata);
            end else begin
                check_eq("m0_rd_data_nonowner", m0_rd_data, 0);
                if (!e_wr) check_eq("m1_rd_data", m1_rd_data, e_rdata);
            end
            e_resp = 0;
        end else if (pend0 || pend1) begin
`ifdef ARB_ROUND_ROBIN_EN
            win = (pend0 && pend1) ? pref : !pend0;
`else
            win = !pend0;
`endif
            wr = p_wr[win];
            a  = p_addr[win];
            check_eq("issue_mem_cs", mem_cs, 1);
            check_eq("issue_mem_we", mem_we, wr);
            check_eq("issue_mem_addr", {2'b00, mem_addr}, {2'b00, a[31:2]});
            check_eq("issue_mem_be", mem_be, wr ? p_be[win] : 4'hF);
            if (wr) check_eq("issue_mem_wdata", mem_wdata, p_data[win]);
            check_no_ready();
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (p_be[win][b]) ref_mem[a[5:2]][8*b +: 8] = p_data[win][8*b +: 8];
            end else begin
                e_rdata = ref_mem[a[5:2]];
            end
            e_resp  = 1;
            e_owner = win;
            e_wr    = wr;
            pref    = !win;
        end else begin
            check_eq("idle_mem_cs", mem_cs, 0);
            check_no_ready();
        end
    endtask

    task automatic tick(input bit rnd);
        bit dropped [2];
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        dropped[0] = 0;
        dropped[1] = 0;
        for (int k = 0; k < 2; k++) begin
            if (seen_wr[k])      p_wr[k] = 0;
            else if (seen_rd[k]) p_rd[k] = 0;
            seen_wr[k] = 0;
            seen_rd[k] = 0;
        end
        if (rnd) begin
            if (e_resp && ($urandom % 4 == 0)) begin
                if (e_wr) p_wr[e_owner] = 0;
                else      p_rd[e_owner] = 0;
                dropped[e_owner] = 1;
            end
            for (int k = 0; k < 2; k++) begin
                if (!p_rd[k] && !p_wr[k] && !dropped[k] && ($urandom % 3 == 0)) begin
                    int t;
                    t = int'($urandom % 4);
                    p_rd[k]   = (t != 2);
                    p_wr[k]   = (t >= 2);
                    p_addr[k] = 32'(($urandom % 16) * 4 + ($urandom % 4));
                    p_be[k]   = 4'(($urandom % 15) + 1);
                    p_data[k] = $urandom;
                end
            end
        end
    endtask

    task automatic set_req(input int k, input bit rd, input bit wr, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] d);
        p_rd[k]   = rd;
        p_wr[k]   = wr;
        p_addr[k] = a;
        p_be[k]   = be;
        p_data[k] = d;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((p_rd[0] || p_wr[0] || p_rd[1] || p_wr[1] || e_resp) && n < 40) begin
            tick(0);
            n++;
        end
        check_eq("drain_timeout", n < 40, 1);
    endtask

    task automatic check_all_zero(input string where);
        check_eq({where, "_mem_cs"}, mem_cs, 0);
        check_eq({where, "_mem_we"}, mem_we, 0);
        check_eq({where, "_mem_addr"}, {2'b00, mem_addr}, 0);
        check_eq({where, "_mem_be"}, mem_be, 0);
        check_eq({where, "_mem_wdata"}, mem_wdata, 0);
        check_eq({where, "_m0_rd_data"}, m0_rd_data, 0);
        check_eq({where, "_m1_rd_data"}, m1_rd_data, 0);
        check_no_ready();
    endtask

    initial begin
        int m0_cnt, m1_cnt;
        logic [31:0] v;
        for (int i = 0; i < 16; i++) begin
            v = $urandom;
            tb_mem[i]  = v;
            ref_mem[i] = v;
        end
        tb_mem[4]  = 32'hDEADBEEF;
        ref_mem[4] = 32'hDEADBEEF;
        mem_rdata = 32'd0;
        for (int k = 0; k < 2; k++) set_req(k, 0, 0, 0, 0, 0);
        e_resp = 0; e_owner = 0; e_wr = 0; pref = 0; e_rdata = 0;

        // reset with a request already waiting
        rstb = 1'b0;
        set_req(0, 1, 0, 32'h0000_0010, 4'h0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rstb = 1'b1;

        // word 4 read by m0
        tick(0);
        tick(0);
        drain();

        // m1 byte-lane write
        set_req(1, 0, 1, 32'h0000_0022, 4'h4, 32'h00AB0000);
        tick(0);
        tick(0);
        drain();

        // both reading continuously for 8 cycles
        m0_cnt = 0;
        m1_cnt = 0;
        set_req(0, 1, 0, 32'h0000_0018, 4'h0, 0);
        set_req(1, 1, 0, 32'h0000_001C, 4'h0, 0);
        for (int c = 0; c < 8; c++) begin
            tick(0);
            if (m0_rd_ready) m0_cnt++;
            if (m1_rd_ready) m1_cnt++;
            p_rd[0] = 1;
            p_rd[1] = 1;
        end
`ifdef ARB_ROUND_ROBIN_EN
        check_eq("contend_m0_grants", m0_cnt, 2);
        check_eq("contend_m1_grants", m1_cnt, 2);
`else
        check_eq("contend_m0_grants", m0_cnt, 4);
        check_eq("contend_m1_grants", m1_cnt, 0);
`endif
        p_rd[0] = 0;
        drain();

        // simultaneous write and read from m0
        set_req(0, 1, 1, 32'h0000_0030, 4'hF, 32'h1234_5678);
        repeat (4) tick(0);
        drain();

        // reset in the response cycle of an m1 read
        set_req(1, 1, 0, 32'h0000_0014, 4'h0, 0);
        tick(0);
        rstb = 1'b0;
        #1;
        check_all_zero("rst_resp");
        e_resp = 0;
        pref   = 0;
        set_req(0, 1, 0, 32'h0000_0024, 4'h0, 0);
        @(negedge clk);
        check_all_zero("rst_hold");
        @(posedge clk);
        #1;
        rstb = 1'b1;
        tick(0);
        tick(0);
        drain();

        // randomized traffic
        for (int c = 0; c < 400; c++) tick(1);
        for (int k = 0; k < 2; k++) if (!e_resp) ;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  core clock; rstb  in  1  asynchronous active-low reset.
REQ-002 SHALL have requester-0 (core data port) ports: m0_addr in 32, m0_rd_req in 1, m0_wr_req in 1, m0_be in 4, m0_wr_data in 32, m0_rd_ready out 1, m0_wr_ready out 1, m0_rd_data out 32.
REQ-003 SHALL have requester-1 (loader/debug port) ports m1_*, identical in name suffix, direction and width to REQ-002.
REQ-004 SHALL have memory ports: mem_cs out 1, mem_we out 1, mem_addr out 30 (word address = m_addr[31:2]), mem_be out 4, mem_wdata out 32, mem_rdata in 32 (valid one cycle after mem_cs).
REQ-005 Parameter: none; all widths fixed.

Function
REQ-006 SHALL implement states IDLE and RESP plus an owner register (0/1); state and owner are registered.
REQ-007 In IDLE with any request pending: SHALL select a winner per REQ-012, drive mem_* combinationally from the winner, latch owner and access type, and go to RESP next cycle.
REQ-008 In IDLE with no request: mem_cs=0, stay IDLE.
REQ-009 In RESP: SHALL assert exactly one of m<owner>_rd_ready or m<owner>_wr_ready for one cycle, matching the latched type; m<owner>_rd_data = mem_rdata in that cycle; then return to IDLE.
REQ-010 Latency: ready one cycle after the issue cycle; back-to-back grants SHALL allow one access every 2 cycles.
REQ-011 Requesters hold req, addr, be and data stable until they see ready; a request dropped during RESP SHALL still receive its ready pulse.
REQ-012 Both requesters pending in IDLE: fixed priority gives m0 the grant (see REQ-018 for the alternative).
REQ-013 A requester with both rd_req and wr_req high SHALL be served as a write; its read stays pending and is served as a separate access.
REQ-014 The non-owner's ready outputs SHALL be 0 in every cycle; mx_rd_data of the non-owner SHALL be 0.
REQ-015 mem_we=1 only for writes; mem_be = winner be for writes, 4'hF for reads.

Reset
REQ-016 On rstb low, asynchronously: state=IDLE, owner=0, rr pointer=0; all outputs 0 (mem_cs, mem_we, mem_addr, mem_be, mem_wdata, all ready, all rd_data).
REQ-017 Reset asserted in RESP SHALL abort the access with no ready pulse; first cycle after release is IDLE.

Configuration
REQ-018 Macro ARB_ROUND_ROBIN_EN: when defined, contention in IDLE SHALL be granted to the requester that did not win the most recent grant (1-bit pointer updated on every grant, reset to favour m0); when undefined, fixed m0 priority per REQ-012.

Verification
REQ-019 m0 read addr 0x0000_0010, mem word 4 = 0xDEADBEEF -> mem_cs=1, mem_addr=4, mem_be=F in issue cycle; m0_rd_ready=1, m0_rd_data=0xDEADBEEF next cycle.
REQ-020 m1 write addr 0x0000_0022, be=4'h4, data 0x00AB0000 -> mem_we=1, mem_addr=8, mem_be=4'h4; m1_wr_ready pulse next cycle, m0 ready stays 0.
REQ-021 m0 and m1 reads held high together for 8 cycles -> without macro: m0 granted every issue slot, m1 starved; with ARB_ROUND_ROBIN_EN: grants alternate m0,m1,m0,m1.
REQ-022 m0 rd_req and wr_req both high -> write issued first (mem_we=1), wr_ready, then read issued, rd_ready.
REQ-023 rstb pulsed low in RESP of m1 read -> no m1_rd_ready, all outputs 0, next m0 request served normally 2 cycles later.
